// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with hardwired-zero x0, pending scoreboard
// and a sequential clear engine. Define REGFILE_BYPASS_EN for write-through forwarding to read ports.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_RF,
    input  logic [AW-1:0]       A3,
    input  logic [XLEN-1:0]     WD3,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      pend,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                clear_req,
    output logic                busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [XLEN-1:0]  mem [1:NREGS-1];
    logic [NREGS-1:0] pend_q;
    logic             wr_ok;
    logic             rsv_ok;

    // Address 0 and anything past the last architectural register have no storage behind them.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    assign wr_ok  = we_RF && !busy && in_range(A3);
    assign rsv_ok = rsv_en && !busy && in_range(rsv_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            pend_q <= '0;
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        mem[A3]    <= WD3;
                        pend_q[A3] <= 1'b0;
                    end
                    // Placed after the write so a same-cycle reservation keeps the bit set.
                    if (rsv_ok) begin
                        pend_q[rsv_addr] <= 1'b1;
                    end
                    if (clear_req) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= AW'(1);
                    end
                end
                CLEAR: begin
                    mem[cnt]    <= '0;
                    pend_q[cnt] <= 1'b0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            valid;
        logic [XLEN-1:0] stored;
        logic            stored_pend;

        assign addr        = ra[k*AW +: AW];
        assign valid       = in_range(addr);
        assign stored      = valid ? mem[addr] : '0;
        assign stored_pend = valid & pend_q[addr];

`ifdef REGFILE_BYPASS_EN
        logic hit;
        logic rsv_hit;

        // A write landing on this port's address this cycle is forwarded, and its pending bit
        // is retired early unless a new producer reserves the same register.
        assign hit     = wr_ok && (A3 == addr);
        assign rsv_hit = rsv_ok && (rsv_addr == addr);
        assign rd[k*XLEN +: XLEN] = hit ? WD3 : stored;
        assign pend[k]            = hit ? (rsv_hit & stored_pend) : stored_pend;
`else
        assign rd[k*XLEN +: XLEN] = stored;
        assign pend[k]            = stored_pend;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized self-checking bench for regfile_mp against an array-based reference model.
// Honors REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk;
    logic                rst;
    logic                we_RF;
    logic [AW-1:0]       A3;
    logic [XLEN-1:0]     WD3;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      pend;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                clear_req;
    logic                busy;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: register contents, pending flags, and the clear window measured in edges.
    logic [31:0] mMem  [NREGS];
    logic        mPend [NREGS];
    bit          mBusy;
    int          edgeNum;
    int          clearEdge;
    int          busyCycles;

    regfile_mp #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .NRD  (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we_RF    (we_RF),
        .A3       (A3),
        .WD3      (WD3),
        .ra       (ra),
        .rd       (rd),
        .pend     (pend),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .clear_req(clear_req),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] a3, input logic [31:0] wd3,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                 input logic rsv, input logic [AW-1:0] rsvA,
                                 input logic clr, input logic rstIn, input bit check);
        logic [AW-1:0] addrs [2];
        we_RF     = we;
        A3        = a3;
        WD3       = wd3;
        ra        = {ra1, ra0};
        rsv_en    = rsv;
        rsv_addr  = rsvA;
        clear_req = clr;
        rst       = rstIn;
        addrs[0]  = ra0;
        addrs[1]  = ra1;
        #1;
        if (busy === 1'b1) busyCycles++;
        if (check) begin
            checkOutput("busy", 32'(busy), 32'(mBusy));
            for (int k = 0; k < NRD; k++) begin
                logic [31:0] eRd;
                logic        ePend;
                eRd   = (addrs[k] == 0) ? 32'h0 : mMem[addrs[k]];
                ePend = (addrs[k] == 0) ? 1'b0 : mPend[addrs[k]];
`ifdef REGFILE_BYPASS_EN
                if (we && !mBusy && a3 != 0 && a3 == addrs[k]) begin
                    eRd = wd3;
                    if (!(rsv && rsvA == a3)) ePend = 1'b0;
                end
`endif
                checkOutput($sformatf("rd%0d[x%0d]", k, addrs[k]), rd[k*XLEN +: XLEN], eRd);
                checkOutput($sformatf("pend%0d[x%0d]", k, addrs[k]), 32'(pend[k]), 32'(ePend));
            end
        end
        @(posedge clk);
        edgeNum++;
        if (rstIn) begin
            for (int i = 0; i < NREGS; i++) begin
                mMem[i]  = 32'h0;
                mPend[i] = 1'b0;
            end
            mBusy = 1'b0;
        end else if (mBusy) begin
            int j;
            j        = edgeNum - clearEdge;
            mMem[j]  = 32'h0;
            mPend[j] = 1'b0;
            if (j == NREGS - 1) mBusy = 1'b0;
        end else begin
            if (we && a3 != 0) begin
                mMem[a3]  = wd3;
                mPend[a3] = 1'b0;
            end
            if (rsv && rsvA != 0) mPend[rsvA] = 1'b1;
            if (clr) begin
                mBusy     = 1'b1;
                clearEdge = edgeNum;
            end
        end
        @(negedge clk);
    endtask

    task automatic readSweep();
        for (int i = 0; i < NREGS; i++) begin
            applyStimulus(1'b0, '0, 32'h0, AW'(i), AW'(NREGS - 1 - i), 1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic fillAll(input logic [31:0] value);
        for (int i = 1; i < NREGS; i++) begin
            applyStimulus(1'b1, AW'(i), value, AW'($urandom), AW'($urandom),
                          1'b1, AW'((i + 7) % NREGS), 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        edgeNum    = 0;
        clearEdge  = 0;
        mBusy      = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < NREGS; i++) begin
            mMem[i]  = 32'h0;
            mPend[i] = 1'b0;
        end

        applyStimulus(1'b0, '0, 32'h0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 32'h0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        readSweep();

        for (int i = 0; i < NREGS; i++) begin
            applyStimulus(1'b1, AW'(i), 32'(i + 'h100), AW'($urandom), AW'($urandom),
                          1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        readSweep();

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd3, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 32'h0, 5'd5, 5'd5, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b0, '0, 32'h0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 32'h0, 5'd1, 5'd7, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd7, 32'h1234_5678, 5'd1, 5'd7, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 32'h0, 5'd1, 5'd7, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 32'h0, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd7, 32'h8765_4321, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 32'h0, 5'd7, 5'd7, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 32'h0, 5'd0, 5'd0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        repeat (400) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
                          AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom),
                          1'($urandom_range(0, 39) == 0), 1'b0, 1'b1);
        end
        repeat (NREGS) begin
            applyStimulus(1'b0, '0, 32'h0, AW'($urandom), AW'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b1);
        end

        fillAll(32'hA5A5A5A5);
        busyCycles = 0;
        applyStimulus(1'b0, '0, 32'h0, 5'd1, 5'd31, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int guard = 0; guard < 40 && busy === 1'b1; guard++) begin
            applyStimulus(1'b1, AW'($urandom), 32'hFFFF0000, AW'($urandom), AW'($urandom),
                          1'b1, AW'($urandom), 1'b1, 1'b0, 1'b1);
        end
        checkOutput("busyLen", 32'(busyCycles), 32'd31);
        readSweep();

        fillAll(32'hA5A5A5A5);
        applyStimulus(1'b0, '0, 32'h0, 5'd2, 5'd20, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        repeat (10) begin
            applyStimulus(1'b0, '0, 32'h0, AW'($urandom), AW'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, '0, 32'h0, 5'd25, 5'd30, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        readSweep();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the pipelined core. It replaces the fixed 32×32, two-read, one-write register memory. It adds a configurable port count, a hardwired-zero register 0, a per-register pending scoreboard for hazard detection, and a sequential clear engine for pipeline flush and debug. It sits between decode (read ports, reservations) and writeback (write port).

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers, 2..64; register 0 is hardwired zero.
- NRD, 2, number of read ports, 1..4.
- AW, $clog2(NREGS), address width; derived, not to be overridden.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- we_RF  in  1  write enable.
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- ra  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- pend  out  NRD  bit k set means register ra[k] has an outstanding reservation.
- rsv_en  in  1  reserve a destination register (set its pending bit).
- rsv_addr  in  AW  register to reserve.
- clear_req  in  1  start a sequential zeroing of all registers and pending bits.
- busy  out  1  clear engine is active.

## Operation
- **Storage:** NREGS-1 physical registers of XLEN bits, indices 1..NREGS-1. Index 0 always reads 0, ignores writes, and is never pending.
- **Out-of-range addresses** (value ≥ NREGS): reads return 0 with pend 0. Writes and reservations to them are ignored.
- **Write:** when we_RF=1, busy=0 and 0<A3<NREGS, the register takes WD3 at the clock edge and its pending bit clears.
- **Reads:** combinational and independent per port. Any number of ports may read the same address.
- **Scoreboard:** when rsv_en=1, busy=0 and 0<rsv_addr<NREGS, the pending bit sets at the edge.
  - Reservation and write to the same address in the same cycle: the reservation wins and the bit stays set, for back-to-back producers.
  - pend[k] is the registered pending bit of ra[k], modified only as described under Configuration.
- **FSM:** two states, IDLE and CLEAR.
  - IDLE → CLEAR when clear_req=1. The counter loads 1 and busy=1 from the next cycle.
  - In CLEAR, each cycle zeroes register [cnt] and its pending bit, then increments cnt.
  - When cnt==NREGS-1 that register is zeroed and the FSM returns to IDLE.
  - clear_req is ignored while in CLEAR.
  - While busy=1, we_RF and rsv_en are ignored, and reads return current contents, including partially cleared state.
- **Reset:** rst=1 at an edge zeroes all registers and pending bits, sets state IDLE and cnt to 0. rst overrides everything, including a clear in progress.

## Timing
- Reset values: busy=0, pend=0, rd=0 for every address.
- Read latency is 0 cycles, combinational from ra.
- Without bypass, write-to-read latency is 1 cycle.
- Reservation-to-pend latency is 1 cycle.
- Clear duration: NREGS-1 cycles with busy=1, starting the cycle after clear_req is sampled. busy falls in the cycle after the last register is zeroed. With the default parameters, clear_req at edge N gives busy=1 for edges N+1..N+31.
- rst asserted mid-clear: busy=0 after that edge and the remaining registers are zero.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-through forwarding is enabled.
  - If we_RF=1, busy=0, A3==ra[k] and A3!=0, then rd[k]=WD3 in the same cycle.
  - pend[k] is forced to 0 in the same cycle unless rsv_en also targets that address.
- `REGFILE_BYPASS_EN` undefined: no forwarding. rd shows the stored value and pend shows the registered bit; the new value appears the cycle after the write.

## Test plan
- **Write/read sweep:** write WD3=i+0x100 to A3=i for i=0..31, then read all addresses on both ports. Required: rd=0 at address 0 and i+0x100 elsewhere.
- **Bypass:** write 0xDEADBEEF to register 5 with ra[0]=5 in the same cycle.
  - With `REGFILE_BYPASS_EN`: rd[0]=0xDEADBEEF in that cycle.
  - Without it: the old value in that cycle and 0xDEADBEEF in the next.
- **Scoreboard:** set rsv_en with rsv_addr=7, then ra[1]=7.
  - Required: pend[1]=1 from the next cycle.
  - Write 7 alone: pend[1]=0 after the edge (same cycle with bypass).
  - Write 7 together with a reservation of 7: pend stays 1.
- **Register 0:** reserve and write address 0 with 0xFFFFFFFF. Required: rd=0 and pend=0 at address 0.
- **Clear:** fill all registers with 0xA5A5A5A5, pulse clear_req, and attempt writes during busy.
  - Required: busy high for exactly 31 cycles.
  - The writes are ignored.
  - All registers read 0 afterwards.
- **Reset mid-clear:** assert rst 10 cycles into a clear. Required: busy=0 and all registers and pend=0 on the next cycle.
